dvi_rx_axis: RTL and testbench

DVI_RX_AXIS -- requirements
Module: dvi_rx_axis

---
 rtl/dvi_rx_axis.sv | 229 ++++++++++++++++++++++
 tb/tb_dvi_rx_axis.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dvi_rx_axis.sv
// DVI/TMDS receiver front end producing an AXI4-Stream pixel stream.
// Symbols are classified and decoded in one register stage. A three-state
// lock FSM then moves each pixel through a one-entry hold register into the
// AXI output register. The hold register is what makes tlast possible: a
// pixel only leaves it once we know whether it ends the frame.
// Optional build macro: DVI_RX_STATS_EN adds the active width/height counters.
//
// state    | meaning
// UNLOCKED | counting consecutive all-channel control tokens
// BLANK    | locked, in horizontal or vertical blanking
// ACTIVE   | locked, capturing pixels of a visible line
module dvi_rx_axis #(
  parameter int LOCK_TOKENS = 64
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [9:0]  tmds0,
  input  logic [9:0]  tmds1,
  input  logic [9:0]  tmds2,
  output logic        axis_tvalid,
  input  logic        axis_tready,
  output logic [31:0] axis_tdata,
  output logic        axis_tlast,
  output logic        hsync,
  output logic        vsync,
  output logic        locked,
  output logic        overflow,
  output logic [11:0] h_active,
  output logic [11:0] v_active
);

  localparam int CNT_W = $clog2(LOCK_TOKENS + 1);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, BLANK = 2'd1, ACTIVE = 2'd2} state_e;

  function automatic logic is_token(input logic [9:0] q);
    return (q == 10'h354) || (q == 10'h0AB) || (q == 10'h154) || (q == 10'h2AB);
  endfunction

  // Returns {c1, c0} for a control token.
  function automatic logic [1:0] token_ctl(input logic [9:0] q);
    case (q)
      10'h0AB: return 2'b01;
      10'h154: return 2'b10;
      10'h2AB: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d    = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  logic [2:0]  tok_q;
  logic [23:0] pix_q;
  logic        hsync_q, vsync_q;
  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        hold_vld_q, hold_vld_d;
  logic [23:0] hold_data_q, hold_data_d;
  logic        out_vld_q, out_vld_d, out_last_q, out_last_d, ovf_q, ovf_d;
  logic [23:0] out_data_q, out_data_d;
  logic        rel, rel_last;
  logic        all_tok, all_dat;

  assign all_tok = &tok_q;
  assign all_dat = ~|tok_q;

  // Classification/decode stage; sync bits only follow channel-0 tokens.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      tok_q   <= '0;
      pix_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      tok_q <= {is_token(tmds2), is_token(tmds1), is_token(tmds0)};
      pix_q <= {tmds_decode(tmds2), tmds_decode(tmds1), tmds_decode(tmds0)};
      if (is_token(tmds0)) {vsync_q, hsync_q} <= token_ctl(tmds0);
    end
  end

  // FSM state, lock counter, hold and output registers.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q     <= UNLOCKED;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic; a capture releases the previously held pixel.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    rel         = 1'b0;
    rel_last    = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (all_tok) begin
          if (cnt_q < CNT_W'(LOCK_TOKENS)) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(LOCK_TOKENS)) begin
            state_d = BLANK;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      BLANK, ACTIVE: begin
        if (all_dat) begin
          state_d     = ACTIVE;
          rel         = hold_vld_q;
          hold_vld_d  = 1'b1;
          hold_data_d = pix_q;
        end else if (all_tok) begin
          state_d = BLANK;
          if (state_q == BLANK && vsync_q && hold_vld_q) begin
            rel        = 1'b1;
            rel_last   = 1'b1;
            hold_vld_d = 1'b0;
          end
        end else begin
          state_d    = UNLOCKED;
          cnt_d      = '0;
          hold_vld_d = 1'b0;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        cnt_d      = '0;
        hold_vld_d = 1'b0;
      end
    endcase
  end

  // AXI output register; a release into a stalled full register is dropped.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    if (out_vld_q && axis_tready) out_vld_d = 1'b0;
    if (rel) begin
      if (!out_vld_q || axis_tready) begin
        out_vld_d  = 1'b1;
        out_last_d = rel_last;
        out_data_d = hold_data_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign axis_tvalid = out_vld_q;
  assign axis_tdata  = {8'h00, out_data_q};
  assign axis_tlast  = out_last_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign locked      = (state_q != UNLOCKED);
  assign overflow    = ovf_q;

`ifdef DVI_RX_STATS_EN
  logic [11:0] pix_cnt_q, line_cnt_q, h_act_q, v_act_q, line_next;
  logic        vs_prev_q, eol, vs_rise;

  function automatic logic [11:0] sat_inc(input logic [11:0] x);
    return (x == 12'hFFF) ? x : x + 12'd1;
  endfunction

  assign eol       = (state_q == ACTIVE) && all_tok;
  assign vs_rise   = vsync_q && !vs_prev_q;
  assign line_next = eol ? sat_inc(line_cnt_q) : line_cnt_q;

  // Width counts pixels per ACTIVE run; height counts line ends per frame.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      h_act_q    <= '0;
      v_act_q    <= '0;
      vs_prev_q  <= 1'b0;
    end else begin
      vs_prev_q <= vsync_q;
      if (state_q == UNLOCKED) begin
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
      end else begin
        if (all_dat) pix_cnt_q <= (state_q == BLANK) ? 12'd1 : sat_inc(pix_cnt_q);
        if (eol) h_act_q <= pix_cnt_q;
        if (vs_rise) begin
          v_act_q    <= line_next;
          line_cnt_q <= '0;
        end else begin
          line_cnt_q <= line_next;
        end
      end
    end
  end

  assign h_active = h_act_q;
  assign v_active = v_act_q;
`else
  assign h_active = '0;
  assign v_active = '0;
`endif

endmodule

// File: tb/tb_dvi_rx_axis.sv
// Directed bench for dvi_rx_axis: lock, a 4x2 frame from a vector table,
// overflow under back-pressure, loss of lock mid-line and async reset.
module tb_dvi_rx_axis;

  localparam logic [9:0] T_BLK = 10'h354;
  localparam logic [9:0] T_HS  = 10'h0AB;
  localparam logic [9:0] T_VS  = 10'h154;

  typedef struct {
    logic [9:0]  t2;
    logic [9:0]  t1;
    logic [9:0]  t0;
    logic [31:0] data;
    logic        last;
  } pix_vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  tmds0, tmds1, tmds2;
  logic        tvalid, tready, tlast;
  logic [31:0] tdata;
  logic        hsync, vsync, locked, overflow;
  logic [11:0] h_active, v_active;

  int tests = 0;
  int fails = 0;
  logic [31:0] got_data[$];
  logic        got_last[$];
  pix_vec_t    frame_v[8];

  dvi_rx_axis #(.LOCK_TOKENS(64)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .tmds0(tmds0), .tmds1(tmds1), .tmds2(tmds2),
    .axis_tvalid(tvalid), .axis_tready(tready), .axis_tdata(tdata), .axis_tlast(tlast),
    .hsync(hsync), .vsync(vsync), .locked(locked), .overflow(overflow),
    .h_active(h_active), .v_active(v_active)
  );

  always #5 clk = ~clk;

  // Record every handshake mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      got_data.push_back(tdata);
      got_last.push_back(tlast);
    end
  end

  task automatic tick(input logic [9:0] a2, input logic [9:0] a1, input logic [9:0] a0);
    tmds2 = a2;
    tmds1 = a1;
    tmds0 = a0;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic lock_seq(input string name);
    repeat (64) tick(T_BLK, T_BLK, T_BLK);
    check({name, "_63"}, 32'(locked), 32'd0);
    tick(T_BLK, T_BLK, T_BLK);
    check({name, "_64"}, 32'(locked), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_tail[3];
    logic        stable;
    int          base;

    // Decoded bytes: 1FF->01 100->00 0FF->FF 200->FF 155->FF 055->01 3AA->FF 1F0->10 00F->EF
    frame_v[0] = '{10'h100, 10'h0FF, 10'h1FF, 32'h0000FF01, 1'b0};
    frame_v[1] = '{10'h1FF, 10'h100, 10'h100, 32'h00010000, 1'b0};
    frame_v[2] = '{10'h1F0, 10'h00F, 10'h055, 32'h0010EF01, 1'b0};
    frame_v[3] = '{10'h200, 10'h155, 10'h3AA, 32'h00FFFFFF, 1'b0};
    frame_v[4] = '{10'h00F, 10'h1F0, 10'h0FF, 32'h00EF10FF, 1'b0};
    frame_v[5] = '{10'h055, 10'h1FF, 10'h1F0, 32'h00010110, 1'b0};
    frame_v[6] = '{10'h3AA, 10'h055, 10'h00F, 32'h00FF01EF, 1'b0};
    frame_v[7] = '{10'h155, 10'h200, 10'h100, 32'h00FFFF00, 1'b1};

    rst_n  = 1'b0;
    tready = 1'b1;
    tmds0  = T_BLK;
    tmds1  = T_BLK;
    tmds2  = T_BLK;
    #12;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_sync", {30'd0, vsync, hsync}, 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_active", {8'd0, h_active, v_active}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    lock_seq("lock");

    // 4x2 frame: hsync blanking between lines, vsync blanking after.
    for (int i = 0; i < 4; i++) tick(frame_v[i].t2, frame_v[i].t1, frame_v[i].t0);
    repeat (3) tick(T_BLK, T_BLK, T_HS);
    check("hsync_token", {30'd0, vsync, hsync}, 32'd1);
    for (int i = 4; i < 8; i++) tick(frame_v[i].t2, frame_v[i].t1, frame_v[i].t0);
    check("hsync_held", {30'd0, vsync, hsync}, 32'd1);
    repeat (4) tick(T_BLK, T_BLK, T_VS);
    check("vsync_token", {30'd0, vsync, hsync}, 32'd2);
    repeat (3) tick(T_BLK, T_BLK, T_BLK);
    check("frame_count", got_data.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      check($sformatf("frame_data%0d", i), got_data[i], frame_v[i].data);
      check($sformatf("frame_last%0d", i), 32'(got_last[i]), 32'(frame_v[i].last));
    end
`ifdef DVI_RX_STATS_EN
    check("h_active", 32'(h_active), 32'd4);
    check("v_active", 32'(v_active), 32'd2);
`else
    check("h_active_off", 32'(h_active), 32'd0);
    check("v_active_off", 32'(v_active), 32'd0);
`endif
    check("ovf_before", 32'(overflow), 32'd0);

    // Back-pressure across three pixels: first stays on the bus, second dropped.
    tready = 1'b0;
    tick(10'h0FF, 10'h0FF, 10'h0FF);
    tick(10'h100, 10'h100, 10'h100);
    tick(10'h1FF, 10'h1FF, 10'h1FF);
    tick(T_BLK, T_BLK, T_BLK);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_tvalid", 32'(tvalid), 32'd1);
    stable = 1'b1;
    repeat (3) begin
      if (tdata !== 32'h00FFFFFF || tlast !== 1'b0) stable = 1'b0;
      tick(T_BLK, T_BLK, T_BLK);
    end
    check("ovf_tdata_stable", 32'(stable), 32'd1);
    check("ovf_tdata", tdata, 32'h00FFFFFF);
    tready = 1'b1;
    repeat (2) tick(T_BLK, T_BLK, T_BLK);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Loss of lock mid-line: the held pixel must vanish.
    tick(10'h200, 10'h100, 10'h1FF);
    tick(10'h00F, 10'h00F, 10'h00F);
    tick(T_BLK, 10'h0FF, 10'h0FF);
    tick(T_BLK, T_BLK, T_BLK);
    check("unlock_2clk", 32'(locked), 32'd0);
    repeat (63) tick(T_BLK, T_BLK, T_BLK);
    check("relock_63", 32'(locked), 32'd0);
    tick(T_BLK, T_BLK, T_BLK);
    check("relock_64", 32'(locked), 32'd1);
    exp_tail[0] = 32'h00FFFFFF;
    exp_tail[1] = 32'h00010101;
    exp_tail[2] = 32'h00FF0001;
    check("drop_count", got_data.size(), 32'd11);
    for (int i = 0; i < 3 && 8 + i < got_data.size(); i++)
      check($sformatf("drop_data%0d", i), got_data[8 + i], exp_tail[i]);

    // Asynchronous reset in ACTIVE with a pixel waiting on the bus.
    tready = 1'b0;
    tick(10'h0FF, 10'h0FF, 10'h0FF);
    tick(10'h100, 10'h100, 10'h100);
    tick(10'h1FF, 10'h1FF, 10'h1FF);
    check("pre_rst_tvalid", 32'(tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tvalid", 32'(tvalid), 32'd0);
    check("async_locked", 32'(locked), 32'd0);
    check("async_tdata", tdata, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    tready = 1'b1;
    base   = got_data.size();
    stable = 1'b1;
    repeat (10) begin
      tick(10'h0FF, 10'h100, 10'h1FF);
      if (tvalid !== 1'b0) stable = 1'b0;
    end
    check("post_rst_quiet", 32'(stable), 32'd1);
    check("post_rst_none", got_data.size(), 32'(base));
    lock_seq("rst_relock");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
